// File: rtl/ysyx_25040111_clint_pkg.sv
// Shared constants and types for the core-local interruptor.
package ysyx_25040111_clint_pkg;

  // Register offsets relative to BASE.
  localparam logic [15:0] MSIP_OFF     = 16'h0000;
  localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
  localparam logic [15:0] MTIME_OFF    = 16'hBFF8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Both bus paths use the same two-state handshake machine.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } fsm_state_t;

  typedef enum logic [1:0] {
    REG_NONE     = 2'd0,
    REG_MSIP     = 2'd1,
    REG_MTIMECMP = 2'd2,
    REG_MTIME    = 2'd3
  } reg_kind_t;

  // Result of decoding one bus address.
  typedef struct packed {
    reg_kind_t  kind;
    logic [2:0] hart;
    logic       hi;
  } dec_t;

  // Byte-lane merge of a 32-bit write into an existing word.
  function automatic logic [31:0] strb_merge(input logic [31:0] old,
                                             input logic [31:0] data,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = data[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ysyx_25040111_clint_prescaler.sv
// Prescaler for mtime: counts 0..DIV-1 and pulses tick on the wrap cycle.
module ysyx_25040111_clint_prescaler #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  logic [15:0] cnt;

  assign tick = (cnt == 16'(DIV - 1));

  // Free-running divider; never disturbed by bus writes.
  always_ff @(posedge clk) begin
    if (rst) cnt <= 16'h0;
    else if (tick) cnt <= 16'h0;
    else cnt <= cnt + 16'h1;
  end

endmodule

// File: rtl/ysyx_25040111_clint_irq.sv
// Core-local interruptor: mtime, per-hart mtimecmp/msip, AXI4-Lite slave.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | path free; read side holds arready, write side waits AW+W
// ST_RESP | response valid on R/B channel, held until the master is ready
module ysyx_25040111_clint_irq
  import ysyx_25040111_clint_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int          NHART    = 1,
  parameter int          TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      araddr,
  input  logic             arvalid,
  output logic             arready,
  output logic [31:0]      rdata,
  output logic [1:0]       rresp,
  output logic             rvalid,
  input  logic             rready,
  input  logic [31:0]      awaddr,
  input  logic             awvalid,
  output logic             awready,
  input  logic [31:0]      wdata,
  input  logic [3:0]       wstrb,
  input  logic             wvalid,
  output logic             wready,
  output logic [1:0]       bresp,
  output logic             bvalid,
  input  logic             bready,
  output logic [NHART-1:0] mtip,
  output logic [NHART-1:0] msip
);

  // Misaligned offsets and hart indices beyond NHART decode as unmapped.
  function automatic dec_t decode(input logic [31:0] addr);
    dec_t d;
    d.kind = REG_NONE;
    d.hart = 3'd0;
    d.hi   = 1'b0;
    if (addr[31:16] == BASE[31:16] && addr[1:0] == 2'b00) begin
      if (addr[15:14] == MSIP_OFF[15:14]) begin
        if (32'(addr[13:2]) < 32'(NHART)) begin
          d.kind = REG_MSIP;
          d.hart = addr[4:2];
        end
      end else if (addr[15:14] == MTIMECMP_OFF[15:14]) begin
        if (32'(addr[13:3]) < 32'(NHART)) begin
          d.kind = REG_MTIMECMP;
          d.hart = addr[5:3];
          d.hi   = addr[2];
        end
      end else if (addr[15:3] == MTIME_OFF[15:3]) begin
        d.kind = REG_MTIME;
        d.hi   = addr[2];
      end
    end
    return d;
  endfunction

  fsm_state_t  rd_st, wr_st;
  logic        wr_open;
  logic        rd_fire, wr_fire;
  dec_t        rdec, wdec;
  logic        tick;
  logic [63:0] mtime;
  logic        sh_valid;
  logic [31:0] sh_hi;
  logic [31:0] rd_val;
  logic        rd_err;
  logic [7:0]  sip_all;
  logic [63:0] cmp_all [8];

  assign rdec    = decode(araddr);
  assign wdec    = decode(awaddr);
  assign awready = wr_open & awvalid & wvalid;
  assign wready  = awready;
  assign rd_fire = arvalid & arready;
  assign wr_fire = awready;

  ysyx_25040111_clint_prescaler #(.DIV(TICK_DIV)) u_presc (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // mtime: a bus write takes priority and swallows a coincident tick.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtime <= 64'h0;
    end else if (wr_fire && wdec.kind == REG_MTIME) begin
      if (wdec.hi) mtime[63:32] <= strb_merge(mtime[63:32], wdata, wstrb);
      else         mtime[31:0]  <= strb_merge(mtime[31:0], wdata, wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // Shadow of mtime[63:32] for coherent low-then-high reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh_valid <= 1'b0;
      sh_hi    <= 32'h0;
    end else begin
      if (rd_fire) begin
        if (rdec.kind == REG_MTIME && !rdec.hi) begin
          sh_valid <= 1'b1;
          sh_hi    <= mtime[63:32];
        end else begin
          sh_valid <= 1'b0;
        end
      end
      if (wr_fire && wdec.kind == REG_MTIME) sh_valid <= 1'b0;
    end
  end

  for (genvar h = 0; h < 8; h++) begin : g_hart
    if (h < NHART) begin : g_live
      logic [63:0] cmp_q;
      logic        sip_q;
      logic        tip_q;

      // Per-hart registers and the registered timer compare.
      always_ff @(posedge clk) begin
        if (rst) begin
          cmp_q <= '1;
          sip_q <= 1'b0;
          tip_q <= 1'b0;
        end else begin
          if (wr_fire && wdec.kind == REG_MTIMECMP && wdec.hart == 3'(h)) begin
            if (wdec.hi) cmp_q[63:32] <= strb_merge(cmp_q[63:32], wdata, wstrb);
            else         cmp_q[31:0]  <= strb_merge(cmp_q[31:0], wdata, wstrb);
          end
          if (wr_fire && wdec.kind == REG_MSIP && wdec.hart == 3'(h) && wstrb[0])
            sip_q <= wdata[0];
          tip_q <= (mtime >= cmp_q);
        end
      end

      assign cmp_all[h] = cmp_q;
      assign sip_all[h] = sip_q;
      assign mtip[h]    = tip_q;
      assign msip[h]    = sip_q;
    end else begin : g_tie
      assign cmp_all[h] = '1;
      assign sip_all[h] = 1'b0;
    end
  end

  // Read data mux over the current register values.
  always_comb begin
    rd_val = 32'h0;
    rd_err = 1'b0;
    case (rdec.kind)
      REG_MSIP:     rd_val = {31'h0, sip_all[rdec.hart]};
      REG_MTIMECMP: rd_val = rdec.hi ? cmp_all[rdec.hart][63:32]
                                     : cmp_all[rdec.hart][31:0];
      REG_MTIME: begin
        if (!rdec.hi)     rd_val = mtime[31:0];
        else if (sh_valid) rd_val = sh_hi;
        else               rd_val = mtime[63:32];
      end
      default:      rd_err = 1'b1;
    endcase
  end

  // Read path: accept one address, hold the response until rready.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_st   <= ST_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rdata   <= 32'h0;
      rresp   <= RESP_OKAY;
    end else begin
      case (rd_st)
        ST_IDLE: begin
          if (rd_fire) begin
            rd_st   <= ST_RESP;
            arready <= 1'b0;
            rvalid  <= 1'b1;
            rdata   <= rd_val;
            rresp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            arready <= 1'b1;
          end
        end
        ST_RESP: begin
          if (rready) begin
            rd_st   <= ST_IDLE;
            rvalid  <= 1'b0;
            arready <= 1'b1;
          end
        end
        default: rd_st <= ST_IDLE;
      endcase
    end
  end

  // Write path: address and data are taken together, then B is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_st   <= ST_IDLE;
      wr_open <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= RESP_OKAY;
    end else begin
      case (wr_st)
        ST_IDLE: begin
          if (wr_fire) begin
            wr_st   <= ST_RESP;
            wr_open <= 1'b0;
            bvalid  <= 1'b1;
            bresp   <= (wdec.kind == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            wr_open <= 1'b1;
          end
        end
        ST_RESP: begin
          if (bready) begin
            wr_st   <= ST_IDLE;
            wr_open <= 1'b1;
            bvalid  <= 1'b0;
          end
        end
        default: wr_st <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_25040111_clint_irq.sv
// Bench for the CLINT: vector table, corner sequences and a random run
// checked against an arithmetic model of the register map.
module tb_ysyx_25040111_clint_irq;

  localparam logic [31:0] BASE  = 32'h0200_0000;
  localparam int          NHART = 2;
  localparam int          DIV   = 4;

  localparam logic [31:0] A_MSIP0 = BASE + 32'h0000;
  localparam logic [31:0] A_MSIP1 = BASE + 32'h0004;
  localparam logic [31:0] A_MSIP2 = BASE + 32'h0008;
  localparam logic [31:0] A_CMP0L = BASE + 32'h4000;
  localparam logic [31:0] A_CMP0H = BASE + 32'h4004;
  localparam logic [31:0] A_CMP1L = BASE + 32'h4008;
  localparam logic [31:0] A_CMP1H = BASE + 32'h400C;
  localparam logic [31:0] A_CMP2L = BASE + 32'h4010;
  localparam logic [31:0] A_MTL   = BASE + 32'hBFF8;
  localparam logic [31:0] A_MTH   = BASE + 32'hBFFC;
  localparam logic [31:0] A_HOLE  = BASE + 32'h8000;
  localparam logic [31:0] A_OUT   = 32'h0300_0000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic arvalid = 1'b0, rready = 1'b0, awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0;
  logic [3:0]  wstrb = '0;
  logic        arready, rvalid, awready, wready, bvalid;
  logic [31:0] rdata;
  logic [1:0]  rresp, bresp;
  logic [NHART-1:0] mtip, msip;

  ysyx_25040111_clint_irq #(.BASE(BASE), .NHART(NHART), .TICK_DIV(DIV)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mtip(mtip), .msip(msip)
  );

  always #5 clk = ~clk;

  // Number of clock edges since reset was last released.
  int cyc = 0;
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic tmo(input string name);
    n_total++;
    $display("FAIL %s: timed out, got no handshake expected one within 20 cycles", name);
  endtask

  // ---------------- reference model ----------------
  longint unsigned anc_val;
  int              anc_c;
  longint unsigned m_cmp [NHART];
  bit              m_sip [NHART];
  bit              sh_v;
  logic [31:0]     sh_val;

  // mtime after edge c: ticks land on every edge whose index is a multiple of DIV.
  function automatic longint unsigned mt_at(input int c);
    return anc_val + 64'(c / DIV) - 64'(anc_c / DIV);
  endfunction

  task automatic model_reset();
    anc_val = 0; anc_c = 0; sh_v = 0; sh_val = 0;
    for (int h = 0; h < NHART; h++) begin m_cmp[h] = '1; m_sip[h] = 0; end
  endtask

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // 0 unmapped, 1 msip, 2 mtimecmp, 3 mtime
  function automatic int mdec(input logic [31:0] a, output int h, output bit hi);
    longint off;
    h = 0; hi = 0;
    if (a < BASE || a >= BASE + 32'h10000 || a % 4 != 0) return 0;
    off = longint'(a - BASE);
    if (off < 'h4000) begin h = int'(off / 4); return (h < NHART) ? 1 : 0; end
    if (off < 'h8000) begin
      h = int'((off - 'h4000) / 8); hi = ((off - 'h4000) % 8) >= 4;
      return (h < NHART) ? 2 : 0;
    end
    if (off == 'hBFF8) return 3;
    if (off == 'hBFFC) begin hi = 1; return 3; end
    return 0;
  endfunction

  task automatic model_write(input int k, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
    int h; bit hi; int kind; longint unsigned cur;
    kind = mdec(a, h, hi);
    resp = (kind == 0) ? 2'b10 : 2'b00;
    if (kind == 1 && s[0]) m_sip[h] = d[0];
    if (kind == 2) begin
      cur = m_cmp[h];
      if (hi) cur[63:32] = mrg(cur[63:32], d, s); else cur[31:0] = mrg(cur[31:0], d, s);
      m_cmp[h] = cur;
    end
    if (kind == 3) begin
      cur = mt_at(k - 1);
      if (hi) cur[63:32] = mrg(cur[63:32], d, s); else cur[31:0] = mrg(cur[31:0], d, s);
      anc_val = cur; anc_c = k; sh_v = 0;
    end
  endtask

  task automatic model_read(input int k, input logic [31:0] a,
                            output logic [31:0] d, output logic [1:0] resp);
    int h; bit hi; int kind; longint unsigned cur;
    kind = mdec(a, h, hi);
    d = 0; resp = 2'b00;
    cur = mt_at(k - 1);
    case (kind)
      1: begin d = {31'h0, m_sip[h]}; sh_v = 0; end
      2: begin d = hi ? m_cmp[h][63:32] : m_cmp[h][31:0]; sh_v = 0; end
      3: begin
        if (!hi) begin d = cur[31:0]; sh_val = cur[63:32]; sh_v = 1; end
        else begin d = sh_v ? sh_val : cur[63:32]; sh_v = 0; end
      end
      default: begin resp = 2'b10; sh_v = 0; end
    endcase
  endtask

  // ---------------- bus tasks ----------------
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp, output int k);
    int n;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1; n = 0;
    while (!awready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) tmo("aw_wait");
    @(posedge clk); #1; k = cyc;
    @(negedge clk); awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    #1; n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) tmo("b_wait");
    resp = bresp;
    @(posedge clk); #1; bready = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp, output int k);
    int n;
    @(negedge clk);
    araddr = a; arvalid = 1'b1;
    #1; n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) tmo("ar_wait");
    @(posedge clk); #1; k = cyc;
    @(negedge clk); arvalid = 1'b0; rready = 1'b1;
    #1; n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) tmo("r_wait");
    d = rdata; resp = rresp;
    @(posedge clk); #1; rready = 1'b0;
  endtask

  // Model-checked transactions.
  task automatic mwrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [1:0] r, er; int k;
    bus_write(a, d, s, r, k);
    model_write(k, a, d, s, er);
    chk("bresp", r, er);
  endtask

  task automatic mread(input string name, input logic [31:0] a, output logic [31:0] d);
    logic [1:0] r, er; logic [31:0] ed; int k;
    bus_read(a, d, r, k);
    model_read(k, a, ed, er);
    chk(name, d, ed);
    chk({name, "_resp"}, r, er);
  endtask

  // Per-cycle check of the interrupt outputs against the model.
  task automatic idle_check(input int n);
    longint unsigned mt;
    repeat (n) begin
      @(negedge clk);
      mt = mt_at(cyc - 1);
      for (int h = 0; h < NHART; h++) begin
        chk("mtip", mtip[h], (cyc == 0) ? 0 : (mt >= m_cmp[h]));
        chk("msip", msip[h], m_sip[h]);
      end
    end
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t vt [16];
  logic [31:0] cand [12];

  initial begin
    logic [31:0] d, d0, ed;
    logic [1:0]  r, er;
    int k, n;

    vt[0]  = '{1'b1, A_MSIP0, 32'h0000_0001, 4'h1, 32'h0,         2'b00};
    vt[1]  = '{1'b0, A_MSIP0, 32'h0,         4'h0, 32'h1,         2'b00};
    vt[2]  = '{1'b1, A_MSIP0, 32'h0,         4'h0, 32'h0,         2'b00};
    vt[3]  = '{1'b0, A_MSIP0, 32'h0,         4'h0, 32'h1,         2'b00};
    vt[4]  = '{1'b1, A_MSIP1, 32'hFFFF_FFFF, 4'hF, 32'h0,         2'b00};
    vt[5]  = '{1'b0, A_MSIP1, 32'h0,         4'h0, 32'h1,         2'b00};
    vt[6]  = '{1'b1, A_MSIP2, 32'h1,         4'hF, 32'h0,         2'b10};
    vt[7]  = '{1'b0, A_MSIP2, 32'h0,         4'h0, 32'h0,         2'b10};
    vt[8]  = '{1'b0, A_HOLE,  32'h0,         4'h0, 32'h0,         2'b10};
    vt[9]  = '{1'b1, A_CMP1L, 32'h1234_5678, 4'h3, 32'h0,         2'b00};
    vt[10] = '{1'b0, A_CMP1L, 32'h0,         4'h0, 32'hFFFF_5678, 2'b00};
    vt[11] = '{1'b0, A_CMP1H, 32'h0,         4'h0, 32'hFFFF_FFFF, 2'b00};
    vt[12] = '{1'b1, A_CMP1H, 32'h0,         4'hF, 32'h0,         2'b00};
    vt[13] = '{1'b0, A_CMP1H, 32'h0,         4'h0, 32'h0,         2'b00};
    vt[14] = '{1'b0, A_OUT,   32'h0,         4'h0, 32'h0,         2'b10};
    vt[15] = '{1'b1, A_MSIP1, 32'h0,         4'h1, 32'h0,         2'b00};

    cand = '{A_MSIP0, A_MSIP1, A_MSIP2, A_CMP0L, A_CMP0H, A_CMP1L,
             A_CMP1H, A_CMP2L, A_MTL, A_MTH, A_HOLE, A_OUT};

    // Reset values
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_rresp", rresp, 0);
    chk("rst_bresp", bresp, 0);
    chk("rst_mtip", mtip, 0);
    chk("rst_msip", msip, 0);
    rst = 1'b0;

    // First mtime reads
    mread("mtime_lo0", A_MTL, d);
    mread("mtime_hi0", A_MTH, d);
    chk("mtime_hi0_zero", d, 0);

    // Vector table
    for (int i = 0; i < 16; i++) begin
      if (vt[i].wr) begin
        bus_write(vt[i].addr, vt[i].data, vt[i].strb, r, k);
        model_write(k, vt[i].addr, vt[i].data, vt[i].strb, er);
        chk($sformatf("vec%0d_bresp", i), r, vt[i].exp_resp);
      end else begin
        bus_read(vt[i].addr, d, r, k);
        model_read(k, vt[i].addr, ed, er);
        chk($sformatf("vec%0d_rdata", i), d, vt[i].exp_data);
        chk($sformatf("vec%0d_rresp", i), r, vt[i].exp_resp);
      end
      idle_check(1);
    end

    // mtime low-word wrap and coherent high read
    mwrite(A_MTL, 32'hFFFF_FFFF, 4'hF);
    mwrite(A_MTH, 32'h0, 4'hF);
    mread("wrap_lo", A_MTL, d0);
    mread("wrap_hi", A_MTH, d);
    chk("wrap_hi_vs_lo", d, (d0 == 32'h0) ? 1 : 0);
    // A high read with no preceding low read returns the live value
    mread("live_hi", A_MTH, d);

    // Timer interrupt rising and falling
    mwrite(A_MTH, 32'h0, 4'hF);
    mwrite(A_MTL, 32'd90, 4'hF);
    mwrite(A_CMP0L, 32'd100, 4'hF);
    mwrite(A_CMP0H, 32'h0, 4'hF);
    idle_check(80);
    chk("mtip_risen", mtip[0], 1);
    mwrite(A_CMP0L, 32'hFFFF_FFFF, 4'hF);
    idle_check(2);
    chk("mtip_dropped", mtip[0], 0);
    mwrite(A_CMP0H, 32'hFFFF_FFFF, 4'hF);
    idle_check(2);

    // Same-cycle read and write of msip[0]: the read sees the old value
    mwrite(A_MSIP0, 32'h1, 4'h1);
    @(negedge clk);
    araddr = A_MSIP0; arvalid = 1'b1;
    awaddr = A_MSIP0; wdata = 32'h0; wstrb = 4'h1; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    chk("rw_both_ready", arready & awready, 1);
    @(posedge clk); #1; k = cyc;
    model_read(k, A_MSIP0, ed, er);
    model_write(k, A_MSIP0, 32'h0, 4'h1, er);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    chk("rw_rdata_old", rdata, 1);
    chk("rw_bvalid", bvalid, 1);
    rready = 1'b1; bready = 1'b1;
    @(posedge clk); #1; rready = 1'b0; bready = 1'b0;
    idle_check(2);
    chk("rw_msip_new", msip[0], 0);

    // Random traffic against the model
    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      a = cand[$urandom_range(0, 11)];
      if ($urandom_range(0, 1) == 1) mwrite(a, $urandom, 4'($urandom_range(0, 15)));
      else mread("rand_rdata", a, d);
      idle_check(1);
    end

    // rready held low, then reset mid-wait
    @(negedge clk);
    araddr = A_MTL; arvalid = 1'b1;
    #1; n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    if (n >= 20) tmo("hold_ar_wait");
    @(posedge clk); #1; k = cyc;
    model_read(k, A_MTL, ed, er);
    @(negedge clk);
    arvalid = 1'b0;
    d0 = rdata;
    chk("hold_rdata", d0, ed);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_rvalid", rvalid, 1);
      chk("hold_rdata_stable", rdata, d0);
      chk("hold_arready", arready, 0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_rvalid", rvalid, 0);
    chk("rst_mid_arready", arready, 0);
    rst = 1'b0;
    model_reset();
    mread("post_rst_lo", A_MTL, d);
    chk("post_rst_small", d < 4, 1);
    mread("post_rst_hi", A_MTH, d);
    idle_check(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ysyx_25040111_clint_irq.md
# ysyx_25040111_clint_irq

Parametrised core-local interruptor: a free-running 64-bit `mtime` with a programmable prescaler, per-hart `mtimecmp` and `msip` registers, and registered timer/software interrupt outputs. It sits on the NPC's AXI4-Lite MMIO crossbar beside the UART and SRAM slaves. It replaces the read-only timer slave: it adds a write channel, error responses, coherent 64-bit reads and interrupt generation.

## Interface
- `BASE`, 32'h0200_0000, byte base address; the decode window is `BASE`..`BASE+0xFFFF`.
- `NHART`, 1, number of harts (1..8).
- `TICK_DIV`, 1, number of `clk` cycles per `mtime` increment (1..65535).
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `araddr` in 32, `arvalid` in 1, `arready` out 1: read address channel.
- `rdata` out 32, `rresp` out 2, `rvalid` out 1, `rready` in 1: read data channel.
- `awaddr` in 32, `awvalid` in 1, `awready` out 1: write address channel.
- `wdata` in 32, `wstrb` in 4, `wvalid` in 1, `wready` out 1: write data channel.
- `bresp` out 2, `bvalid` out 1, `bready` in 1: write response channel.
- `mtip` out NHART: timer interrupt pending, one bit per hart.
- `msip` out NHART: software interrupt pending, one bit per hart.

## Operation
- Register map, as offsets from `BASE`. Any unmapped offset, or a hart index ≥ NHART, returns resp 2'b10 (SLVERR). Writes to it are dropped and reads return 0.
  - `0x0000+4h`: msip[h]. Only bit 0 is implemented; other bits read as 0.
  - `0x4000+8h`: mtimecmp[h] low word. `0x4004+8h`: mtimecmp[h] high word.
  - `0xBFF8`: mtime low word. `0xBFFC`: mtime high word.
- Reset values: `mtime`=0, every `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF, `msip`=0, `mtip`=0, prescaler=0.
- Reset values of the bus outputs: `arready`=`awready`=`wready`=`rvalid`=`bvalid`=0, `rdata`=0, `rresp`=`bresp`=0.
- Prescaler counts 0..TICK_DIV-1. On the cycle it wraps to 0, `mtime` increments by 1. With TICK_DIV=1, `mtime` increments every cycle.
- `mtime` wraps from 2^64-1 to 0 with no flag.
- Writes honour `wstrb` byte lanes. A software write to `mtime` in the same cycle as a tick wins: the tick is lost and the prescaler is not reset.
- Coherent read: a read of the `mtime` low word latches `mtime[63:32]` into a shadow register. The next read of the `mtime` high word returns the shadow.
  - The shadow is invalidated by any intervening read of a different address, and by any write to `mtime`.
  - A high-word read with no valid shadow returns the live value.
- `mtip[h]` is the registered result of the unsigned compare `mtime >= mtimecmp[h]`, using the current-cycle register values.
- `msip[h]` directly reflects register bit 0.
- Read and write paths are independent FSMs.
  - Read FSM: IDLE → RESP.
  - Write FSM: IDLE → RESP. The write path does not accept address and data separately.
- A read and a write to the same register handshaking in the same cycle: the read returns the pre-write value.

## Timing
- Read path:
  - In IDLE, `arready`=1.
  - The AR handshake occurs at cycle N. `rvalid` rises at N+1 with `rdata`/`rresp` stable.
  - The path leaves RESP on the cycle `rvalid&rready`, and `arready` returns to 1 in the next cycle.
  - Throughput is one read per 2 cycles.
- Write path:
  - `awready`=`wready`=1 only in IDLE and only while `awvalid&wvalid` are both high.
  - The register update is visible at N+1, and `bvalid` rises at N+1.
  - The path holds in RESP until `bready`.
- `rdata`, `rresp` and `bresp` hold while the corresponding valid is high and ready is low.
- The new `mtip` value appears 1 cycle after the `mtime` or `mtimecmp` update that causes it.
- `rst` asserted in any cycle, including mid-handshake: all state returns to reset values at the next edge. An outstanding response is discarded.

## Structure
- Package `ysyx_25040111_clint_pkg` holds:
  - the offset constants `MSIP_OFF`, `MTIMECMP_OFF`, `MTIME_OFF`;
  - the response codes `RESP_OKAY`=2'b00 and `RESP_SLVERR`=2'b10;
  - the FSM state typedef.
- Sub-module `ysyx_25040111_clint_prescaler` takes `clk`, `rst` and `DIV`, and outputs the one-cycle `tick` pulse.
- Everything else lives in the top module, with per-hart registers built in a generate loop.

## Test plan
- Reset, then a read of `0xBFF8` at tick time 10 with TICK_DIV=1 → rdata is within 1 count of `mtime` at the handshake and rresp=00. A read of `0xBFFC` → 0.
- Write `mtime` low/high = 0xFFFF_FFFF/0x0000_0000, then read low → 0x0000_0000 (wrapped) or the live value. The following high-word read returns the shadow: 1 if the low read saw 0x0, otherwise 0.
- Set `mtimecmp[0]`=100 (high word 0) with TICK_DIV=4 → `mtip[0]` rises exactly at `mtime`=100, i.e. 1 cycle after the tick. Writing `mtimecmp[0]`=0xFFFFFFFF_FFFFFFFF → `mtip[0]` drops 1 cycle later.
- Write 1 to `msip[0]` with `wstrb`=4'b0001 → `msip[0]`=1 and bresp=00. Write with `wstrb`=0 → no change.
- Read `BASE+0x8000` → rresp=10 and rdata=0. Write to `msip[NHART]` → bresp=10, with no side effect.
- Hold `rready`=0 for 5 cycles → `rvalid` and `rdata` stay constant and `arready` stays 0. Assert `rst` mid-wait → `rvalid`=0 next cycle and `mtime`=0.
